// File: rtl/module_quan.sv
// Per-element requantizer: signed accumulator -> unsigned 8-bit activation.
// Two-stage pipeline (multiply, then round/shift/offset/saturate), one result per clock.
module module_quan #(
    parameter int DIN_W  = 18,
    parameter int M0_W   = 16,
    parameter int SH_W   = 4,
    parameter int ZP_W   = 8,
    parameter int DOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic [M0_W-1:0]   scale_M0,
    input  logic [SH_W-1:0]   shift,
    input  logic [ZP_W-1:0]   zero_point,
    output logic [DOUT_W-1:0] dout
);

    localparam int PROD_W = DIN_W + M0_W;
    // Extra headroom above the product so prod + rnd and + zero_point cannot wrap.
    localparam int ACC_W  = PROD_W + 2;

    // ---------------- Stage 1: signed x unsigned multiply ----------------
    logic signed [PROD_W:0]   mult_full;
    logic signed [PROD_W-1:0] prod_q;
    logic [SH_W-1:0]          shift_q;
    logic [ZP_W-1:0]          zp_q;

    // scale_M0 is zero-extended so the multiply stays signed without sign-flipping large scales.
    assign mult_full = $signed(din) * $signed({1'b0, scale_M0});

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            shift_q <= '0;
            zp_q    <= '0;
        end else begin
            prod_q  <= mult_full[PROD_W-1:0];
            shift_q <= shift;
            zp_q    <= zero_point;
        end
    end

    // ---------------- Stage 2: round, shift, offset, saturate ----------------
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [ACC_W-1:0]  sum;
    logic [DOUT_W-1:0]        dout_d;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << DOUT_W) - 1);

    always_comb begin
        prod_ext = ACC_W'(prod_q);
        rnd      = '0;
        if (shift_q != '0) begin
            rnd = ACC_W'(1) << (shift_q - SH_W'(1));
        end
        // Floor shift after adding half an LSB gives round-half-up.
        scaled = (prod_ext + rnd) >>> shift_q;
        sum    = scaled + $signed({{(ACC_W-ZP_W){1'b0}}, zp_q});
        dout_d = sum[DOUT_W-1:0];
        if (sum < 0) begin
            dout_d = '0;
        end else if (sum > OUT_MAX) begin
            dout_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= dout_d;
        end
    end

endmodule

// File: tb/tb_module_quan.sv
// Directed-vector bench for module_quan: reset, saturation, rounding, throughput, mid-stream reset.
// Expected values are hand-computed from the requantization formula.
module tb_module_quan;

    logic        clk;
    logic        rst;
    logic [17:0] din;
    logic [15:0] scale_M0;
    logic [3:0]  shift;
    logic [7:0]  zero_point;
    logic [7:0]  dout;

    int n_vec;
    int n_err;
    logic [7:0] exp_q[$];

    module_quan dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .scale_M0   (scale_M0),
        .shift      (shift),
        .zero_point (zero_point),
        .dout       (dout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input int m0, input int sh, input int zp);
        din        = 18'(d);
        scale_M0   = 16'(m0);
        shift      = 4'(sh);
        zero_point = 8'(zp);
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: dout=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Apply one vector in isolation and check its result two edges later.
    task automatic run_vec(input string tag, input int d, input int m0, input int sh,
                           input int zp, input logic [7:0] exp);
        drive(d, m0, sh, zp);
        tick();
        tick();
        check_eq(tag, dout, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(12345, 777, 3, 99);

        // Reset with arbitrary inputs
        tick();
        tick();
        check_eq("reset_hold", dout, 8'd0);

        // First result appears on the second edge after deassertion
        rst = 1'b0;
        drive(1000, 3, 4, 1);
        tick();
        check_eq("post_reset_edge1", dout, 8'd0);
        tick();
        check_eq("post_reset_edge2", dout, 8'd189);

        // Saturation and rounding
        run_vec("neg_sat",        -70718, 1, 5, 1,   8'd0);
        run_vec("pos_sat",         27586, 1, 5, 1,   8'd255);
        run_vec("round_3008",       1000, 3, 4, 1,   8'd189);
        run_vec("shift0_neg",       -100, 1, 0, 128, 8'd28);
        run_vec("half_up_pos",        24, 1, 4, 0,   8'd2);
        run_vec("half_neg_clamp",    -24, 1, 4, 0,   8'd0);
        run_vec("half_neg_zp",       -24, 1, 4, 5,   8'd4);

        // Boundaries
        run_vec("max_din_max_m0", 131071, 65535, 15, 0, 8'd255);
        run_vec("min_din_max_m0", -131072, 65535, 15, 0, 8'd0);
        run_vec("min_din_zp255", -131072, 65535, 15, 255, 8'd0);
        run_vec("scale_zero",      -5000, 0, 7, 77,  8'd77);
        run_vec("shift15_trunc",  131071, 1, 15, 10, 8'd14);
        run_vec("shift15_half",    49152, 1, 15, 0,  8'd2);
        run_vec("shift15_neghalf", -49152, 1, 15, 5, 8'd4);
        run_vec("sum_255",           254, 1, 0, 1,   8'd255);
        run_vec("sum_256",           255, 1, 0, 1,   8'd255);
        run_vec("sum_0",              -5, 1, 0, 5,   8'd0);
        run_vec("sum_1",              -4, 1, 0, 5,   8'd1);

        // Back-to-back vectors, one result per clock, latency 2
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin drive(1000, 3, 4, 1);   exp_q.push_back(8'd189); end
                1: begin drive(-100, 1, 0, 128); exp_q.push_back(8'd28);  end
                2: begin drive(24, 1, 4, 0);     exp_q.push_back(8'd2);   end
                default: begin drive(-24, 1, 4, 0); exp_q.push_back(8'd0); end
            endcase
            tick();
            if (i >= 1) begin
                check_eq("stream", dout, exp_q.pop_front());
            end
        end
        drive(0, 0, 0, 0);
        tick();
        check_eq("stream_last", dout, exp_q.pop_front());

        // Mid-stream reset discards the in-flight result
        drive(0, 0, 0, 200);
        tick();
        tick();
        check_eq("pre_mid_reset", dout, 8'd200);
        drive(131071, 65535, 15, 0);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        check_eq("mid_reset_edge", dout, 8'd0);
        rst = 1'b0;
        tick();
        check_eq("after_reset_1", dout, 8'd0);
        tick();
        check_eq("after_reset_2", dout, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
